// File: rtl/macro_counter_pkg.sv
// macro_counter_pkg
//   Shared types and helpers for the macro counter bank.
//   chan_state_e : per-channel state, IDLE (waiting for a target) or RUN (counting).
//   clog2_min1   : ceil(log2(n)) clamped to at least 1, used to size channel-select fields.
package macro_counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chan_state_e;

   // A single-channel bank still needs a 1-bit select field.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      if (r < 1) begin
         r = 1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/macro_counter_chan.sv
// macro_counter_chan
//   One counter channel: target storage, tick counter, match detect and IDLE/RUN FSM.
//   Ports:
//     clk, rst        rising-edge clock, asynchronous active-low reset
//     load            accepted load strobe (already qualified by the bank)
//     load_data       target value to store
//     tick            count enable
//     clr             synchronous abort (highest priority)
//     mode_reload     1 = restart from zero on match, 0 = stop on match
//     busy            channel is in RUN
//     done            one-cycle pulse on match or on a zero-target load
//     count           current counter value
module macro_counter_chan
   import macro_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             tick,
   input  logic             clr,
   input  logic             mode_reload,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   chan_state_e      state_r,   state_nxt_s;
   logic [WIDTH-1:0] cnt_r,     cnt_nxt_s;
   logic [WIDTH-1:0] storage_r, storage_nxt_s;
   logic             done_r,    done_nxt_s;
   logic [WIDTH:0]   cnt_inc_s;
   logic             match_s;

   // The increment carries one extra bit so an all-ones target still matches exactly.
   assign cnt_inc_s = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
   assign match_s   = (cnt_inc_s == {1'b0, storage_r});

   // Next-state logic: clr beats load, load beats tick.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      storage_nxt_s = storage_r;
      done_nxt_s    = 1'b0;
      if (clr) begin
         state_nxt_s = IDLE;
         cnt_nxt_s   = {WIDTH{1'b0}};
      end else if (load) begin
         storage_nxt_s = load_data;
         cnt_nxt_s     = {WIDTH{1'b0}};
         if (load_data != {WIDTH{1'b0}}) begin
            state_nxt_s = RUN;
         end else begin
            // A zero target is already reached: report it and stay idle.
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
         end
      end else begin
         case (state_r)
            RUN: begin
               if (tick) begin
                  if (match_s) begin
                     done_nxt_s = 1'b1;
                     if (mode_reload) begin
                        cnt_nxt_s = {WIDTH{1'b0}};
                     end else begin
                        cnt_nxt_s   = storage_r;
                        state_nxt_s = IDLE;
                     end
                  end else begin
                     cnt_nxt_s = cnt_inc_s[WIDTH-1:0];
                  end
               end else begin
                  cnt_nxt_s = cnt_r;
               end
            end
            IDLE: begin
               state_nxt_s = IDLE;
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = {WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= {WIDTH{1'b0}};
         storage_r <= {WIDTH{1'b0}};
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         storage_r <= storage_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   assign busy  = (state_r == RUN);
   assign done  = done_r;
   assign count = cnt_r;

endmodule

// File: rtl/macro_counter_bank.sv
// macro_counter_bank
//   NUM_CH independent tick counters with a shared valid/ready target-load port
//   and a registered counter read-back port.
//   Ports:
//     clk, rst                  rising-edge clock, asynchronous active-low reset
//     load_valid/ready          target-load handshake (ready is combinational)
//     load_chan, load_data      channel and target of the load
//     tick, clr, mode_reload    per-channel count enable, abort, reload mode
//     busy, done, done_any      per-channel RUN flag, match pulse, OR of match pulses
//     rd_chan, rd_data          read select and registered counter value (0 if out of range)
module macro_counter_bank
   import macro_counter_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int NUM_CH = 4,
   localparam int CH_W   = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [CH_W-1:0]   load_chan,
   input  logic [WIDTH-1:0]  load_data,
   input  logic [NUM_CH-1:0] tick,
   input  logic [NUM_CH-1:0] clr,
   input  logic [NUM_CH-1:0] mode_reload,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done,
   output logic              done_any,
   input  logic [CH_W-1:0]   rd_chan,
   output logic [WIDTH-1:0]  rd_data
);

   logic [NUM_CH-1:0] busy_s;
   logic [NUM_CH-1:0] done_s;
   logic [WIDTH-1:0]  count_s [NUM_CH];
   logic [NUM_CH-1:0] load_sel_s;
   logic              load_ready_s;
   logic [WIDTH-1:0]  rd_mux_s;
   logic [WIDTH-1:0]  rd_data_r;

   // Load decode: an out-of-range channel matches nothing, so it is never ready.
   always_comb begin
      load_ready_s = 1'b0;
      load_sel_s   = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_chan == CH_W'(i)) begin
            load_ready_s  = !busy_s[i] && !clr[i];
            load_sel_s[i] = load_valid && !busy_s[i] && !clr[i];
         end else begin
            load_sel_s[i] = 1'b0;
         end
      end
   end

   // Read mux: out-of-range selects read as zero.
   always_comb begin
      rd_mux_s = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_chan == CH_W'(i)) begin
            rd_mux_s = count_s[i];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
   end

   // Read-back register captures the counter value before this edge's update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_r <= {WIDTH{1'b0}};
      end else begin
         rd_data_r <= rd_mux_s;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      macro_counter_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .load       (load_sel_s[g]),
         .load_data  (load_data),
         .tick       (tick[g]),
         .clr        (clr[g]),
         .mode_reload(mode_reload[g]),
         .busy       (busy_s[g]),
         .done       (done_s[g]),
         .count      (count_s[g])
      );
   end

   assign load_ready = load_ready_s;
   assign busy       = busy_s;
   assign done       = done_s;
   assign done_any   = |done_s;
   assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_macro_counter_bank.sv
// Scoreboard bench for macro_counter_bank (WIDTH=8, NUM_CH=4).
module tb_macro_counter_bank;

   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [1:0] load_chan;
   logic [7:0] load_data;
   logic [3:0] tick;
   logic [3:0] clr;
   logic [3:0] mode_reload;
   logic [3:0] busy;
   logic [3:0] done;
   logic       done_any;
   logic [1:0] rd_chan;
   logic [7:0] rd_data;

   macro_counter_bank #(
      .WIDTH (WIDTH),
      .NUM_CH(NUM_CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_chan  (load_chan),
      .load_data  (load_data),
      .tick       (tick),
      .clr        (clr),
      .mode_reload(mode_reload),
      .busy       (busy),
      .done       (done),
      .done_any   (done_any),
      .rd_chan    (rd_chan),
      .rd_data    (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       ready;
      logic [3:0] busy;
      logic [3:0] done;
      logic       dany;
      logic [7:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   // Reference model: what each channel is doing, in plain integers.
   int   m_cnt [NUM_CH];
   int   m_tgt [NUM_CH];
   bit   m_run [NUM_CH];
   logic [3:0] drv_mode = 4'b0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = 0;
         m_tgt[c] = 0;
         m_run[c] = 0;
      end
   endtask

   // One clock cycle of stimulus; the model predicts ready now and the outputs after the next edge.
   task automatic cycle(input logic lv, input int lc, input int ld, input logic [3:0] tk,
                        input logic [3:0] cl, input int rc);
      exp_t e;
      bit   acc;
      @(posedge clk);
      #1;
      load_valid  = lv;
      load_chan   = 2'(lc);
      load_data   = 8'(ld);
      tick        = tk;
      clr         = cl;
      mode_reload = drv_mode;
      rd_chan     = 2'(rc);
      e       = '0;
      e.ready = !m_run[lc] && !cl[lc];
      e.rd    = 8'(m_cnt[rc]);
      acc     = lv && e.ready;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cl[c]) begin
            m_run[c] = 0;
            m_cnt[c] = 0;
         end else if (acc && lc == c) begin
            m_tgt[c] = ld;
            m_cnt[c] = 0;
            if (ld != 0) m_run[c] = 1;
            else e.done[c] = 1'b1;
         end else if (m_run[c] && tk[c]) begin
            if (m_cnt[c] + 1 == m_tgt[c]) begin
               e.done[c] = 1'b1;
               if (drv_mode[c]) begin
                  m_cnt[c] = 0;
               end else begin
                  m_cnt[c] = m_tgt[c];
                  m_run[c] = 0;
               end
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
         e.busy[c] = m_run[c];
      end
      e.dany = |e.done;
      q.push_back(e);
   endtask

   // Monitor: ready is checked against this cycle's entry, registered outputs against the previous one.
   initial begin
      exp_t e;
      exp_t prev;
      bit   have_prev;
      have_prev = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            have_prev = 0;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            check("load_ready", 32'(load_ready), 32'(e.ready));
            if (have_prev) begin
               check("busy", 32'(busy), 32'(prev.busy));
               check("done", 32'(done), 32'(prev.done));
               check("done_any", 32'(done_any), 32'(prev.dany));
               check("rd_data", 32'(rd_data), 32'(prev.rd));
            end
            prev      = e;
            have_prev = 1;
         end else begin
            have_prev = 0;
         end
      end
   end

   initial begin
      rst = 1'b0;
      load_valid = 1'b0; load_chan = 2'd0; load_data = 8'd0;
      tick = 4'd0; clr = 4'd0; mode_reload = 4'd0; rd_chan = 2'd0;
      model_reset();
      #2;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset done_any", 32'(done_any), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      #10;
      rst = 1'b1;
      mon_en = 1'b1;

      // Basic one-shot on ch1, target 5.
      cycle(1, 1, 5, 4'b0000, 4'b0000, 1);
      repeat (8) cycle(0, 0, 0, 4'b0010, 4'b0000, 1);

      // Auto-reload on ch2, target 3.
      drv_mode = 4'b0100;
      cycle(1, 2, 3, 4'b0000, 4'b0000, 2);
      repeat (10) cycle(0, 0, 0, 4'b0100, 4'b0000, 2);
      cycle(0, 0, 0, 4'b0000, 4'b0100, 2);
      drv_mode = 4'b0000;

      // Back-pressure on ch0 while ch3 loads alongside.
      cycle(1, 0, 10, 4'b0000, 4'b0000, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 3) cycle(1, 3, 7, 4'b0001, 4'b0000, 0);
         else        cycle(1, 0, 4, 4'b0001, 4'b0000, 0);
      end
      repeat (6) cycle(0, 0, 0, 4'b1001, 4'b0000, 3);

      // Zero target, then full-range target with continuous and gapped ticks.
      cycle(1, 0, 0, 4'b0000, 4'b0000, 0);
      cycle(1, 1, 255, 4'b0000, 4'b0000, 1);
      cycle(1, 2, 255, 4'b0000, 4'b0000, 1);
      for (int i = 0; i < 770; i++) begin
         cycle(0, 0, 0, (i < 258 ? 4'b0010 : 4'b0000) | ((i % 3 == 0) ? 4'b0100 : 4'b0000),
               4'b0000, (i < 260) ? 1 : 2);
      end

      // clr beats a same-cycle load and tick.
      cycle(1, 1, 9, 4'b0000, 4'b0000, 1);
      repeat (3) cycle(0, 0, 0, 4'b0010, 4'b0000, 1);
      cycle(1, 1, 5, 4'b0010, 4'b0010, 1);
      repeat (4) cycle(0, 0, 0, 4'b0010, 4'b0000, 1);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] cl;
         cl = 4'b0000;
         for (int b = 0; b < 4; b++) cl[b] = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) drv_mode = 4'($urandom);
         cycle(1'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
               4'($urandom | $urandom), cl, int'($urandom_range(0, 3)));
      end
      drv_mode = 4'b0000;

      // Asynchronous reset in the middle of a count.
      cycle(1, 3, 200, 4'b0000, 4'b1111, 3);
      cycle(1, 3, 200, 4'b0000, 4'b0000, 3);
      repeat (20) cycle(0, 0, 0, 4'b1000, 4'b0000, 3);
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async busy", 32'(busy), 32'd0);
      check("async done", 32'(done), 32'd0);
      check("async done_any", 32'(done_any), 32'd0);
      check("async rd_data", 32'(rd_data), 32'd0);
      q.delete();
      model_reset();
      @(posedge clk);
      #1;
      check("held busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mon_en = 1'b1;
      repeat (4) cycle(0, 0, 0, 4'b1111, 4'b0000, 3);
      cycle(1, 3, 3, 4'b0000, 4'b0000, 3);
      repeat (5) cycle(0, 0, 0, 4'b1000, 4'b0000, 3);

      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
